// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and the priority-encode helper for the
// eight-input interrupt priority encoder.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int VEC_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Highest set index of an eight-bit vector (bit 7 wins). Returns 0 for an
    // all-zero input; callers only use the result when the input is non-zero.
    function automatic logic [VEC_W-1:0] prio_enc8(input logic [N_REQ-1:0] v);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                idx = VEC_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Single-bit synchronizer for an active-low asynchronous request line,
// followed by one extra flop that turns a high-to-low transition into a
// one-cycle pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_n,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus the previous-sample flop used for edge detection.
    // NOTE: these flops reset to 1 (inactive) so that a line already held low
    // at reset release shows up as a genuine falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its neighbour, giving a true shift chain.
            sync_q[0] <= d_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Previous sample high and current synchronized sample low.
    assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_prio_encoder8.sv
// Eight-input interrupt priority encoder: latches falling edges on req_n as
// pending requests and presents the highest-priority unmasked one as a 3-bit
// vector, held until the CPU acknowledges it.
module irq_prio_encoder8
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_n,
    input  logic             ei_n,
    input  logic [N_REQ-1:0] mask,
    input  logic             ack,
    output logic             irq,
    output logic [VEC_W-1:0] vec,
    output logic [N_REQ-1:0] pend
);

    state_t             state_q, state_d;
    logic               irq_q, irq_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [N_REQ-1:0]   pend_q, pend_d;
    logic [N_REQ-1:0]   fall;
    logic [N_REQ-1:0]   cand;
    logic [N_REQ-1:0]   clr;

    // One synchronizer and edge detector per request line.
    for (genvar g = 0; g < N_REQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .clk   (clk),
            .rst_n (rst_n),
            .d_n   (req_n[g]),
            .fall  (fall[g])
        );
    end

    assign cand = pend_q & ~mask;

    // Next-state, presentation and pending-register update logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (!ei_n && (cand != '0)) begin
                    state_d = PRESENT;
                    irq_d   = 1'b1;
                    vec_d   = prio_enc8(cand);
                end
            end
            PRESENT: begin
                // Vector is frozen here; only the acknowledge moves us on.
                if (ack) begin
                    clr[vec_q] = 1'b1;
                    state_d    = IDLE;
                    irq_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
        // A new edge in the same cycle as the clear keeps the bit set.
        pend_d = (pend_q & ~clr) | fall;
    end

    // State, presentation and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            pend_q  <= pend_d;
        end
    end

    assign irq  = irq_q;
    assign vec  = vec_q;
    assign pend = pend_q;

endmodule

// File: doc/irq_prio_encoder8.md
# irq_prio_encoder8

Eight-input interrupt priority encoder with request latching and a vector/acknowledge handshake. It collects active-low request lines, records each falling edge as a pending request, and presents the highest-priority unmasked pending request to the CPU as a 3-bit binary vector. It is the encode-side counterpart of the 3-to-8 line decoders used for device select, and sits between the peripherals and the CPU interrupt input.

## Interface
- N_REQ, 8, number of request lines; fixed at 8, with vector width 3.
- SYNC_STAGES, 2, number of synchronizer flops per request line.

- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_n  in  8  request lines, active-low, asynchronous to clk; bit 7 is highest priority.
- ei_n  in  1  encoder enable, active-low; gates new presentations only.
- mask  in  8  synchronous, active-high; a set bit hides that pending request from arbitration.
- ack  in  1  CPU acknowledge; sampled only while irq=1.
- irq  out  1  registered; a vector is being presented.
- vec  out  3  registered, true binary index of the presented request.
- pend  out  8  registered pending-request register.

## Operation
- Each req_n bit passes through SYNC_STAGES flops, then one more flop for edge detection.
- A falling edge (previous sample 1, current sample 0) sets pend[i].
- pend[i] clears only on acknowledge of vector i.
- A low level held on req_n does not re-trigger.
- Candidates = pend & ~mask. The winner is the highest set index (7 beats 0).
- State machine has two states, IDLE and PRESENT:
  - IDLE: irq=0. If ei_n=0 and the candidate set is non-zero, load vec with the winner, set irq=1, and go to PRESENT.
  - PRESENT: irq=1 and vec held stable. No preemption by a higher-priority arrival. Changes to ei_n or mask are ignored in this state.
  - PRESENT with ack=1: clear pend[vec], drop irq, and return to IDLE.
- After every acknowledge, irq is low for at least one cycle before the next presentation.
- A new falling edge on bit i in the same cycle as the acknowledge-clear of bit i: the set wins, so pend[i] stays 1.
- ack while in IDLE is ignored.
- Arithmetic is bit-index only; no wrap-around or counters.

## Timing
- Reset values: irq=0, vec=3'b000, pend=8'h00, state IDLE. All synchronizer and edge flops reset to 1 (inactive).
- Consequence of the reset values: a line already held low when rst_n releases is captured as a new request.
- Latency: req_n low sampled at edge N → pend bit set after edge N+2 → irq=1 and vec valid after edge N+3, provided state is IDLE, ei_n=0 and the bit is unmasked.
- Minimum capturable pulse is one full clk period low. Shorter pulses may be lost.
- Acknowledge: ack=1 sampled at edge M while irq=1 → irq=0 and pend bit cleared after edge M. The earliest next irq=1 is after edge M+1.
- Reset asserted mid-operation: all outputs return to their reset values immediately, asynchronously. Any in-flight request is lost unless its line is still low at release.

## Structure
- Shared package `irq_pkg` holds:
  - the N_REQ and VEC_W=3 constants;
  - the state enum {IDLE, PRESENT};
  - a pure function `prio_enc8(logic [7:0]) → logic [2:0]` that returns the highest set index.
- One sub-module, `irq_sync_edge`: a single-bit synchronizer plus falling-edge pulse, instantiated 8 times.
- The top level contains pend, the arbitration logic and the FSM.

## Test plan
- Reset hold: pulse rst_n low with req_n=8'hFF. Expect irq=0, vec=0, pend=0. Then req_n[3] low for 1 cycle → pend=8'h08 after 3 edges and irq=1, vec=3 after 4 edges.
- Priority: drive req_n[1] and req_n[6] low together. Expect vec=6 first. After ack, irq is low for one cycle, then vec=1. After the second ack, pend=0.
- No preemption: while vec=2 is presented, drive req_n[7] low. Expect vec to stay 2 until ack, then the next presentation is vec=7.
- Mask and enable: set mask=8'h20 and pulse req_n[5]. Expect pend[5]=1 and irq=0. Clear mask → irq=1, vec=5. Repeat with ei_n=1 → no irq until ei_n=0.
- Simultaneous: a new falling edge on bit 4 lands in the same cycle ack clears vec=4. Expect pend[4] stays 1 and irq reasserts with vec=4 after the one-cycle gap.
- Reset mid-operation: assert rst_n low while irq=1 and req_n[0] is still low. Expect all outputs cleared at once. After release, the request is re-captured and vec=0 is presented after 4 edges.
